// File: rtl/vga_timing_gen.sv
// Raster timing generator: horizontal/vertical scan counters with registered,
// mutually aligned position, blanking, sync and start-pulse outputs.
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0
) (
    input  logic       pixel_clk,
    input  logic       sys_reset_n,
    input  logic       i_enable,
    output logic [9:0] pixel_x,
    output logic [9:0] pixel_y,
    output logic       video_on,
    output logic       o_hsync,
    output logic       o_vsync,
    output logic       o_line_start,
    output logic       o_frame_start,
    output logic [7:0] o_frame_cnt
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    generate
        if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_size_check
            $error("vga_timing_gen: H_TOTAL and V_TOTAL must not exceed 1024");
        end
    endgenerate

    localparam logic [9:0]  H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST = 10'(V_TOTAL - 1);
    // 11-bit bounds so a sync interval ending exactly at 1024 stays representable
    localparam logic [10:0] H_ACT  = 11'(H_ACTIVE);
    localparam logic [10:0] HS_BEG = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] V_ACT  = 11'(V_ACTIVE);
    localparam logic [10:0] VS_BEG = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END = 11'(V_ACTIVE + V_FP + V_SYNC);

    typedef enum logic {IDLE, RUN} state_t;

    state_t     state_q;
    state_t     state_nx;
    logic [9:0] h_cnt;
    logic [9:0] v_cnt;
    logic [9:0] h_nx;
    logic [9:0] v_nx;
    logic       run_nx;
    logic       frame_start_nx;

    function automatic logic in_range(input logic [9:0] pos, input logic [10:0] lo,
                                      input logic [10:0] hi);
        return ({1'b0, pos} >= lo) && ({1'b0, pos} < hi);
    endfunction

    always_comb begin
        state_nx = i_enable ? RUN : IDLE;
        h_nx     = '0;
        v_nx     = '0;
        if (i_enable && state_q == RUN) begin
            if (h_cnt == H_LAST) begin
                h_nx = '0;
                v_nx = (v_cnt == V_LAST) ? 10'd0 : v_cnt + 10'd1;
            end else begin
                h_nx = h_cnt + 10'd1;
                v_nx = v_cnt;
            end
        end
        run_nx         = (state_nx == RUN);
        frame_start_nx = run_nx && (h_nx == 10'd0) && (v_nx == 10'd0);
    end

    // Output stage: every output is registered from the same next position
    always_ff @(posedge pixel_clk or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            state_q       <= IDLE;
            h_cnt         <= '0;
            v_cnt         <= '0;
            video_on      <= 1'b0;
            o_hsync       <= ~HS_POL;
            o_vsync       <= ~VS_POL;
            o_line_start  <= 1'b0;
            o_frame_start <= 1'b0;
            o_frame_cnt   <= '0;
        end else begin
            state_q       <= state_nx;
            h_cnt         <= h_nx;
            v_cnt         <= v_nx;
            video_on      <= run_nx && ({1'b0, h_nx} < H_ACT) && ({1'b0, v_nx} < V_ACT);
            o_hsync       <= (run_nx && in_range(h_nx, HS_BEG, HS_END)) ? HS_POL : ~HS_POL;
            o_vsync       <= (run_nx && in_range(v_nx, VS_BEG, VS_END)) ? VS_POL : ~VS_POL;
            o_line_start  <= run_nx && (h_nx == 10'd0);
            o_frame_start <= frame_start_nx;
            if (frame_start_nx) begin
                o_frame_cnt <= o_frame_cnt + 8'd1;
            end
        end
    end

    assign pixel_x = h_cnt;
    assign pixel_y = v_cnt;

endmodule
